// File: rtl/reg_file_if.sv
// Bus between the CPU datapath (master) and the register file (slave):
// two decode read ports plus the write-back port.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // No valid/ready pair: a write is accepted on every rising edge with wr_en=1,
  // and the read ports are purely combinational with no acknowledge.
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [15:0]       wr_count;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    input  rd_data_a, rd_data_b, wr_count
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    output rd_data_a, rd_data_b, wr_count
  );
endinterface

// File: rtl/reg_file.sv
// 2R1W general-purpose register file: r0 reads as zero, same-cycle write-to-read
// bypass, and a saturating count of accepted writes.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_file_if.slave  rf
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [15:0]       wr_count_q;
  logic              wr_fire;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // Writes to r0 are dropped entirely, including the count.
  assign wr_fire = rf.wr_en && (rf.wr_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_count_q <= '0;
    end else if (wr_fire) begin
      regs[rf.wr_addr] <= rf.wr_data;
      if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  // Bypass is suppressed during reset so reads show the array being cleared.
  always_comb begin
    rd_a = regs[rf.rd_addr_a];
    if (rst_n && rf.wr_en && (rf.wr_addr == rf.rd_addr_a)) rd_a = rf.wr_data;
    if (rf.rd_addr_a == '0) rd_a = '0;
  end

  always_comb begin
    rd_b = regs[rf.rd_addr_b];
    if (rst_n && rf.wr_en && (rf.wr_addr == rf.rd_addr_b)) rd_b = rf.wr_data;
    if (rf.rd_addr_b == '0) rd_b = '0;
  end

  assign rf.rd_data_a = rd_a;
  assign rf.rd_data_b = rd_b;
  assign rf.wr_count  = wr_count_q;
endmodule

// File: tb/tb_reg_file.sv
// Randomized and directed bench for reg_file against an array-based reference model.
module tb_reg_file;
  logic clk;
  logic rst_n;

  reg_file_if #(.DATA_W(32), .ADDR_W(5)) rf_bus ();

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf_bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [31:0] m_regs [32];
  int          m_count;

  int          n_cmp;
  int          n_err;
  logic [31:0] obs_a;
  logic [31:0] obs_b;
  logic [31:0] obs_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic rst, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd,
                                             input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (rst && we && (wa == ra)) return wd;
    return m_regs[ra];
  endfunction

  // One cycle: drive inputs, optionally compare the combinational outputs, clock, update model.
  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                       input bit chk);
    rst_n            = rst;
    rf_bus.wr_en     = we;
    rf_bus.wr_addr   = wa;
    rf_bus.wr_data   = wd;
    rf_bus.rd_addr_a = ra;
    rf_bus.rd_addr_b = rb;
    #1;
    obs_a   = rf_bus.rd_data_a;
    obs_b   = rf_bus.rd_data_b;
    obs_cnt = {16'd0, rf_bus.wr_count};
    if (chk) begin
      check_eq("rd_a", obs_a, model_read(rst, we, wa, wd, ra));
      check_eq("rd_b", obs_b, model_read(rst, we, wa, wd, rb));
      check_eq("wr_count", obs_cnt, m_count);
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count = 0;
    end else if (we && wa != 5'd0) begin
      m_regs[wa] = wd;
      if (m_count < 65535) m_count++;
    end
    #1;
  endtask

  initial begin
    logic [31:0] cnt_saved;
    logic [31:0] last_d;
    logic [4:0]  wa, ra, rb;
    n_cmp = 0;
    n_err = 0;
    m_count = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    rst_n = 1'b0;
    rf_bus.wr_en = 1'b0;
    rf_bus.wr_addr = '0;
    rf_bus.wr_data = '0;
    rf_bus.rd_addr_a = '0;
    rf_bus.rd_addr_b = '0;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);

    // reset state
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd31, 1'b1);
    check_eq("rst_rd_a", obs_a, 32'd0);
    check_eq("rst_cnt", obs_cnt, 32'd0);

    // 1: reset clears state
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 1'b1);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b1);
    check_eq("t1_r5", obs_a, 32'd0);
    check_eq("t1_cnt", obs_cnt, 32'd0);

    // 2: basic write/read
    drive(1'b1, 1'b1, 5'd31, 32'h12345678, 5'd1, 5'd2, 1'b1);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd31, 1'b1);
    check_eq("t2_r31", obs_b, 32'h12345678);
    check_eq("t2_cnt", obs_cnt, 32'd1);

    // 3: r0 hardwired
    cnt_saved = obs_cnt;
    drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1);
    check_eq("t3_same", obs_a, 32'd0);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    check_eq("t3_next", obs_b, 32'd0);
    check_eq("t3_cnt", obs_cnt, cnt_saved);

    // 4: same-cycle bypass on both ports
    drive(1'b1, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 1'b1);
    drive(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b1);
    check_eq("t4_byp_a", obs_a, 32'hA5A5A5A5);
    check_eq("t4_byp_b", obs_b, 32'hA5A5A5A5);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1);
    check_eq("t4_arr_a", obs_a, 32'hA5A5A5A5);
    check_eq("t4_arr_b", obs_b, 32'hA5A5A5A5);

    // 5: write during reset is lost, no bypass while in reset
    drive(1'b1, 1'b1, 5'd3, 32'h77, 5'd0, 5'd0, 1'b1);
    drive(1'b0, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 1'b1);
    check_eq("t5_nobyp", obs_a, 32'h77);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1);
    check_eq("t5_r3", obs_a, 32'd0);
    drive(1'b1, 1'b1, 5'd3, 32'h99, 5'd0, 5'd0, 1'b1);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1);
    check_eq("t5_after", obs_a, 32'h99);

    // randomized traffic, biased toward address collisions
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        wa = 5'($urandom_range(0, 3));
        ra = 5'($urandom_range(0, 3));
        rb = 5'($urandom_range(0, 3));
      end else begin
        wa = 5'($urandom_range(0, 31));
        ra = 5'($urandom_range(0, 31));
        rb = 5'($urandom_range(0, 31));
      end
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), wa, $urandom,
            ra, rb, 1'b1);
    end

    // 6: counter saturation
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    last_d = 32'd0;
    for (int i = 0; i < 65540; i++) begin
      last_d = $urandom;
      drive(1'b1, 1'b1, 5'd1, last_d, 5'd1, 5'd2, (i % 4096) == 0 || i > 65530);
    end
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd1, 1'b1);
    check_eq("t6_cnt", obs_cnt, 32'h0000FFFF);
    check_eq("t6_r1", obs_a, last_d);
    drive(1'b1, 1'b1, 5'd4, 32'h4444, 5'd4, 5'd1, 1'b1);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd4, 5'd1, 1'b1);
    check_eq("t6_hold", obs_cnt, 32'h0000FFFF);
    check_eq("t6_r4", obs_a, 32'h4444);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
